// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle sequencer.
//   mc_state_t   - sequencer phase encoding (INIT=0 .. HALT=6)
//   PCSRC_*      - next-PC select codes driven on pc_src
//   MEM_TIMEOUT_DEFAULT - default memory-wait watchdog limit
package mc_pkg;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } mc_state_t;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;
   localparam logic [1:0] PCSRC_REG = 2'b11;

   localparam int MEM_TIMEOUT_DEFAULT = 255;

   // Phases that own the shared memory port and are covered by the watchdog.
   function automatic logic is_mem_phase(input mc_state_t s);
      return (s == FETCH) || (s == MEM);
   endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// mc_perf_counters: active-cycle and retired-instruction counters.
//   clk, rst      - clock and synchronous active-high reset
//   count_cycle   - strobe: this cycle is an active (non-INIT, non-HALT) cycle
//   count_retire  - strobe: an instruction completes this cycle
//   cycle_cnt     - active-cycle count, wraps modulo 2^CNT_W
//   instret       - retired-instruction count, wraps modulo 2^CNT_W
module mc_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             count_cycle,
   input  logic             count_retire,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret
);

   // Counter registers; natural overflow gives the modulo wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= {CNT_W{1'b0}};
         instret   <= {CNT_W{1'b0}};
      end else begin
         if (count_cycle) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1'b1);
         end else begin
            cycle_cnt <= cycle_cnt;
         end
         if (count_retire) begin
            instret <= instret + CNT_W'(1'b1);
         end else begin
            instret <= instret;
         end
      end
   end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle MIPS control sequencer (fetch/decode/exec/mem/wb)
// over one shared memory port and one ALU, with halt, memory-wait watchdog and
// performance counters.
//   inputs : clk, rst (sync, active-high), ctl_* decoded control, br_cond,
//            mem_ready
//   outputs: mem_req, mem_we, iord, ir_we, pc_we, pc_src, ab_we, alu_we,
//            mdr_we, rf_we (combinational from state and inputs),
//            halted, err, cycle_cnt, instret
module mc_sequencer #(
   parameter int MEM_TIMEOUT = mc_pkg::MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctl_regwr,
   input  logic             ctl_memwr,
   input  logic             ctl_memrd,
   input  logic             ctl_branch,
   input  logic             ctl_jump,
   input  logic             ctl_jreg,
   input  logic             ctl_link,
   input  logic             ctl_halt,
   input  logic             br_cond,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             ab_we,
   output logic             alu_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret
);
   import mc_pkg::*;

   // wait_cnt never exceeds MEM_TIMEOUT: reaching it without mem_ready halts.
   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   mc_state_t         state_r;
   mc_state_t         state_next_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              err_r;
   logic              timeout_s;
   logic              retire_s;
   logic              count_cycle_s;

   // mem_ready takes priority: a timeout only fires when the access is still pending.
   assign timeout_s     = is_mem_phase(state_r) && !mem_ready && (wait_cnt_r == WAIT_LIMIT);
   assign count_cycle_s = (state_r != INIT) && (state_r != HALT);
   assign err           = err_r;

   // Next-state decode and phase-gated control outputs.
   always_comb begin
      state_next_s = state_r;
      retire_s     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PCSRC_SEQ;
      ab_we        = 1'b0;
      alu_we       = 1'b0;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      halted       = 1'b0;
      case (state_r)
         INIT: begin
            state_next_s = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we        = 1'b1;
               pc_we        = 1'b1;
               pc_src       = PCSRC_SEQ;
               state_next_s = DECODE;
            end else if (timeout_s) begin
               state_next_s = HALT;
            end else begin
               state_next_s = FETCH;
            end
         end
         DECODE: begin
            ab_we = 1'b1;
            if (ctl_halt) begin
               // The halt instruction itself retires.
               state_next_s = HALT;
               retire_s     = 1'b1;
            end else if (ctl_jump) begin
               pc_we  = 1'b1;
               pc_src = ctl_jreg ? PCSRC_REG : PCSRC_JMP;
               if (ctl_link) begin
                  state_next_s = WB;
               end else begin
                  state_next_s = FETCH;
                  retire_s     = 1'b1;
               end
            end else begin
               state_next_s = EXEC;
            end
         end
         EXEC: begin
            alu_we = 1'b1;
            if (ctl_branch) begin
               pc_we        = br_cond;
               pc_src       = PCSRC_BR;
               state_next_s = FETCH;
               retire_s     = 1'b1;
            end else if (ctl_memrd || ctl_memwr) begin
               state_next_s = MEM;
            end else if (ctl_regwr) begin
               state_next_s = WB;
            end else begin
               state_next_s = FETCH;
               retire_s     = 1'b1;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            // A store abandoned by the watchdog must not write.
            mem_we  = ctl_memwr && !timeout_s;
            if (mem_ready) begin
               if (ctl_memrd) begin
                  mdr_we       = 1'b1;
                  state_next_s = WB;
               end else begin
                  state_next_s = FETCH;
                  retire_s     = 1'b1;
               end
            end else if (timeout_s) begin
               state_next_s = HALT;
            end else begin
               state_next_s = MEM;
            end
         end
         WB: begin
            rf_we        = 1'b1;
            state_next_s = FETCH;
            retire_s     = 1'b1;
         end
         HALT: begin
            halted       = 1'b1;
            state_next_s = HALT;
         end
         default: begin
            state_next_s = INIT;
         end
      endcase
   end

   // Phase register, watchdog counter and sticky watchdog error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= INIT;
         wait_cnt_r <= {WAIT_W{1'b0}};
         err_r      <= 1'b0;
      end else begin
         state_r <= state_next_s;
         // Any phase change restarts the count, covering entry to FETCH/MEM.
         if (state_next_s != state_r) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
         end else if (is_mem_phase(state_r) && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         if (timeout_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   mc_perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk          (clk),
      .rst          (rst),
      .count_cycle  (count_cycle_s),
      .count_retire (retire_s),
      .cycle_cnt    (cycle_cnt),
      .instret      (instret)
   );

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: self-checking bench for mc_sequencer. Each instruction is
// described by its class and memory wait counts; expected latency, pulse
// counts and counter values come from the instruction-level timing rules.
module tb_mc_sequencer;

   localparam int TB_TIMEOUT = 4;
   localparam int TB_CNT_W   = 32;

   // instruction classes
   localparam int C_ALU   = 0;  // R-type/immediate with register write
   localparam int C_NOWR  = 1;  // ALU op without register write
   localparam int C_LOAD  = 2;
   localparam int C_STORE = 3;
   localparam int C_BR    = 4;
   localparam int C_JMP   = 5;  // j / jr
   localparam int C_LINK  = 6;  // jal / jalr

   logic clk;
   logic rst;
   logic ctl_regwr, ctl_memwr, ctl_memrd, ctl_branch, ctl_jump;
   logic ctl_jreg, ctl_link, ctl_halt, br_cond, mem_ready;
   logic mem_req, mem_we, iord, ir_we, pc_we, ab_we, alu_we, mdr_we, rf_we;
   logic halted, err;
   logic [1:0] pc_src;
   logic [TB_CNT_W-1:0] cycle_cnt, instret;

   int checks;
   int errors;
   int fw_left, mw_left;
   int n_ir, n_ab, n_alu, n_pcwe, n_rf, n_mdr, n_memwe, n_iord, n_memreq, n_halted;
   logic [1:0] last_pcsrc;
   logic [TB_CNT_W-1:0] exp_cycles, exp_instret;

   mc_sequencer #(
      .MEM_TIMEOUT (TB_TIMEOUT),
      .CNT_W       (TB_CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ctl_regwr  (ctl_regwr),
      .ctl_memwr  (ctl_memwr),
      .ctl_memrd  (ctl_memrd),
      .ctl_branch (ctl_branch),
      .ctl_jump   (ctl_jump),
      .ctl_jreg   (ctl_jreg),
      .ctl_link   (ctl_link),
      .ctl_halt   (ctl_halt),
      .br_cond    (br_cond),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .ab_we      (ab_we),
      .alu_we     (alu_we),
      .mdr_we     (mdr_we),
      .rf_we      (rf_we),
      .halted     (halted),
      .err        (err),
      .cycle_cnt  (cycle_cnt),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   task automatic clear_accum();
      n_ir = 0; n_ab = 0; n_alu = 0; n_pcwe = 0; n_rf = 0; n_mdr = 0;
      n_memwe = 0; n_iord = 0; n_memreq = 0; n_halted = 0;
      last_pcsrc = 2'b00;
   endtask

   // One clock: memory model answers the current request, outputs are sampled
   // mid-cycle, then advance to the next falling edge.
   task automatic do_cycle();
      if (mem_req === 1'b1 && iord === 1'b0) begin
         if (fw_left == 0) mem_ready = 1'b1;
         else begin mem_ready = 1'b0; fw_left--; end
      end else if (mem_req === 1'b1) begin
         if (mw_left == 0) mem_ready = 1'b1;
         else begin mem_ready = 1'b0; mw_left--; end
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (ir_we)   n_ir++;
      if (ab_we)   n_ab++;
      if (alu_we)  n_alu++;
      if (rf_we)   n_rf++;
      if (mdr_we)  n_mdr++;
      if (mem_we)  n_memwe++;
      if (iord)    n_iord++;
      if (mem_req) n_memreq++;
      if (halted)  n_halted++;
      if (pc_we) begin n_pcwe++; last_pcsrc = pc_src; end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      ctl_halt = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_cycles = '0;
      exp_instret = '0;
   endtask

   task automatic test_reset();
      logic [12:0] outs;
      apply_reset();
      #1;
      outs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, ab_we, alu_we, mdr_we, rf_we, halted, err};
      checks++;
      if (outs !== 13'd0) begin errors++; $display("FAIL reset_outputs got %b exp 0", outs); end
      checks++;
      if (cycle_cnt !== 32'd0 || instret !== 32'd0) begin
         errors++; $display("FAIL reset_counters got cyc=%0d ret=%0d exp 0/0", cycle_cnt, instret);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || iord !== 1'b0 || cycle_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_to_fetch got req=%b iord=%b cyc=%0d exp 1/0/0", mem_req, iord, cycle_cnt);
      end
   endtask

   // Runs one instruction from its first FETCH cycle; expectations derive
   // from the per-class latency table plus memory wait cycles.
   task automatic run_instr(input string tag, input int cls, input int wf, input int wm,
                            input logic brc, input logic jreg);
      int lat, e_rf, e_mdr, e_alu, e_pcwe, e_memwe, e_iord, e_memreq;
      logic [1:0] e_pcsrc;
      logic is_mem;
      ctl_regwr  = (cls == C_ALU) || (cls == C_LOAD) || (cls == C_LINK);
      ctl_memwr  = (cls == C_STORE);
      ctl_memrd  = (cls == C_LOAD);
      ctl_branch = (cls == C_BR);
      ctl_jump   = (cls == C_JMP) || (cls == C_LINK);
      ctl_jreg   = ctl_jump ? jreg : 1'($urandom_range(0, 1));
      ctl_link   = (cls == C_LINK);
      ctl_halt   = 1'b0;
      br_cond    = brc;
      is_mem     = (cls == C_LOAD) || (cls == C_STORE);
      case (cls)
         C_ALU:   lat = 4;
         C_NOWR:  lat = 3;
         C_LOAD:  lat = 5;
         C_STORE: lat = 4;
         C_BR:    lat = 3;
         C_JMP:   lat = 2;
         C_LINK:  lat = 3;
         default: lat = 0;
      endcase
      lat      = lat + wf + (is_mem ? wm : 0);
      e_rf     = ctl_regwr ? 1 : 0;
      e_mdr    = is_mem && ctl_memrd ? 1 : 0;
      e_alu    = ctl_jump ? 0 : 1;
      e_pcwe   = 1 + (ctl_jump ? 1 : 0) + ((cls == C_BR && brc) ? 1 : 0);
      e_pcsrc  = ctl_jump ? (jreg ? 2'b11 : 2'b10) : ((cls == C_BR && brc) ? 2'b01 : 2'b00);
      e_memwe  = (cls == C_STORE) ? wm + 1 : 0;
      e_iord   = is_mem ? wm + 1 : 0;
      e_memreq = wf + 1 + e_iord;
      clear_accum();
      fw_left = wf;
      mw_left = wm;
      repeat (lat) do_cycle();
      exp_cycles  = exp_cycles + 32'(lat);
      exp_instret = exp_instret + 32'd1;
      checks++;
      if (mem_req !== 1'b1 || iord !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL %s latency: not in fetch after %0d cycles (req=%b iord=%b halted=%b)", tag, lat, mem_req, iord, halted);
      end
      checks++;
      if (n_rf != e_rf || n_mdr != e_mdr || n_alu != e_alu) begin
         errors++; $display("FAIL %s rf/mdr/alu got %0d/%0d/%0d exp %0d/%0d/%0d", tag, n_rf, n_mdr, n_alu, e_rf, e_mdr, e_alu);
      end
      checks++;
      if (n_ir != 1 || n_ab != 1) begin
         errors++; $display("FAIL %s ir/ab got %0d/%0d exp 1/1", tag, n_ir, n_ab);
      end
      checks++;
      if (n_pcwe != e_pcwe || last_pcsrc !== e_pcsrc) begin
         errors++; $display("FAIL %s pc_we count/src got %0d/%b exp %0d/%b", tag, n_pcwe, last_pcsrc, e_pcwe, e_pcsrc);
      end
      checks++;
      if (n_memwe != e_memwe || n_iord != e_iord || n_memreq != e_memreq) begin
         errors++; $display("FAIL %s mem_we/iord/mem_req got %0d/%0d/%0d exp %0d/%0d/%0d", tag, n_memwe, n_iord, n_memreq, e_memwe, e_iord, e_memreq);
      end
      checks++;
      if (cycle_cnt !== exp_cycles || instret !== exp_instret) begin
         errors++; $display("FAIL %s counters got cyc=%0d ret=%0d exp %0d/%0d", tag, cycle_cnt, instret, exp_cycles, exp_instret);
      end
   endtask

   task automatic test_addu();
      run_instr("addu", C_ALU, 0, 0, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic test_load_waits();
      run_instr("lw_wait3", C_LOAD, 3, 3, 1'b0, 1'b0);
   endtask

   task automatic test_branches();
      run_instr("beq_taken", C_BR, 0, 0, 1'b1, 1'b0);
      run_instr("bne_not_taken", C_BR, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_jumps();
      run_instr("jal", C_LINK, 0, 0, 1'b0, 1'b0);
      run_instr("jr", C_JMP, 0, 0, 1'b1, 1'b1);
      run_instr("j", C_JMP, 1, 0, 1'b0, 1'b0);
      run_instr("jalr", C_LINK, 2, 0, 1'b1, 1'b1);
   endtask

   task automatic test_store_and_limit();
      run_instr("sw", C_STORE, 0, 2, 1'b0, 1'b0);
      run_instr("nop_alu", C_NOWR, 0, 0, 1'b1, 1'b0);
      // Ready arriving exactly at the timeout count completes the access.
      run_instr("lw_at_limit", C_LOAD, TB_TIMEOUT, TB_TIMEOUT, 1'b0, 1'b0);
      run_instr("sw_at_limit", C_STORE, TB_TIMEOUT, TB_TIMEOUT, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         run_instr("random", int'($urandom_range(0, 6)), int'($urandom_range(0, TB_TIMEOUT)),
                   int'($urandom_range(0, TB_TIMEOUT)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_halt_opcode();
      int wf;
      logic [TB_CNT_W-1:0] cyc_at_halt;
      wf = int'($urandom_range(0, 3));
      ctl_halt = 1'b1;
      ctl_jump = 1'($urandom_range(0, 1));
      ctl_regwr = 1'($urandom_range(0, 1));
      clear_accum();
      fw_left = wf;
      mw_left = 0;
      repeat (wf + 2) do_cycle();
      exp_cycles  = exp_cycles + 32'(wf + 2);
      exp_instret = exp_instret + 32'd1;
      checks++;
      if (halted !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL halt_opcode state got halted=%b err=%b exp 1/0", halted, err);
      end
      checks++;
      if (cycle_cnt !== exp_cycles || instret !== exp_instret) begin
         errors++; $display("FAIL halt_opcode counters got cyc=%0d ret=%0d exp %0d/%0d", cycle_cnt, instret, exp_cycles, exp_instret);
      end
      cyc_at_halt = cycle_cnt;
      clear_accum();
      repeat (4) do_cycle();
      checks++;
      if (n_halted != 4 || n_memreq != 0 || n_pcwe != 0 || n_ab != 0 || cycle_cnt !== cyc_at_halt) begin
         errors++; $display("FAIL halt_hold got halted=%0d req=%0d pcwe=%0d ab=%0d cyc=%0d exp 4/0/0/0/%0d", n_halted, n_memreq, n_pcwe, n_ab, cycle_cnt, cyc_at_halt);
      end
   endtask

   task automatic test_watchdog_fetch();
      clear_accum();
      ctl_halt = 1'b0;
      fw_left = 1000;
      repeat (TB_TIMEOUT + 1) do_cycle();
      exp_cycles = exp_cycles + 32'(TB_TIMEOUT + 1);
      checks++;
      if (n_memreq != TB_TIMEOUT + 1 || n_halted != 0) begin
         errors++; $display("FAIL wd_fetch_cycles got req=%0d halted=%0d exp %0d/0", n_memreq, n_halted, TB_TIMEOUT + 1);
      end
      checks++;
      if (halted !== 1'b1 || err !== 1'b1) begin
         errors++; $display("FAIL wd_fetch_halt got halted=%b err=%b exp 1/1", halted, err);
      end
      checks++;
      if (instret !== exp_instret || cycle_cnt !== exp_cycles) begin
         errors++; $display("FAIL wd_fetch_counters got cyc=%0d ret=%0d exp %0d/%0d", cycle_cnt, instret, exp_cycles, exp_instret);
      end
   endtask

   task automatic test_watchdog_store();
      ctl_regwr = 1'b0; ctl_memwr = 1'b1; ctl_memrd = 1'b0; ctl_branch = 1'b0;
      ctl_jump = 1'b0; ctl_link = 1'b0; ctl_halt = 1'b0;
      clear_accum();
      fw_left = 0;
      mw_left = 1000;
      repeat (3 + TB_TIMEOUT + 1) do_cycle();
      exp_cycles = exp_cycles + 32'(3 + TB_TIMEOUT + 1);
      checks++;
      if (n_memwe != TB_TIMEOUT || n_iord != TB_TIMEOUT + 1) begin
         errors++; $display("FAIL wd_store_we got mem_we=%0d iord=%0d exp %0d/%0d", n_memwe, n_iord, TB_TIMEOUT, TB_TIMEOUT + 1);
      end
      checks++;
      if (halted !== 1'b1 || err !== 1'b1 || instret !== exp_instret || cycle_cnt !== exp_cycles) begin
         errors++; $display("FAIL wd_store_halt got halted=%b err=%b cyc=%0d ret=%0d exp 1/1/%0d/%0d", halted, err, cycle_cnt, instret, exp_cycles, exp_instret);
      end
   endtask

   task automatic test_reset_mid_store();
      ctl_regwr = 1'b0; ctl_memwr = 1'b1; ctl_memrd = 1'b0; ctl_branch = 1'b0;
      ctl_jump = 1'b0; ctl_link = 1'b0; ctl_halt = 1'b0;
      clear_accum();
      fw_left = 0;
      mw_left = 1000;
      repeat (4) do_cycle();
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || cycle_cnt !== 32'd4) begin
         errors++; $display("FAIL rst_mid_store_pre got req=%b we=%b cyc=%0d exp 1/1/4", mem_req, mem_we, cycle_cnt);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || cycle_cnt !== 32'd0 || instret !== 32'd0) begin
         errors++; $display("FAIL rst_mid_store_drop got req=%b we=%b cyc=%0d ret=%0d exp 0/0/0/0", mem_req, mem_we, cycle_cnt, instret);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || iord !== 1'b0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL rst_mid_store_fetch got req=%b iord=%b we=%b exp 1/0/0", mem_req, iord, mem_we);
      end
      exp_cycles = '0;
      exp_instret = '0;
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      {ctl_regwr, ctl_memwr, ctl_memrd, ctl_branch, ctl_jump, ctl_jreg, ctl_link, ctl_halt} = 8'd0;
      br_cond = 1'b0;
      mem_ready = 1'b0;
      checks = 0;
      errors = 0;
      clear_accum();

      test_reset();
      test_addu();
      test_load_waits();
      test_branches();
      test_jumps();
      test_store_and_limit();
      test_random();
      test_halt_opcode();
      test_reset();
      test_watchdog_fetch();
      test_reset();
      test_watchdog_store();
      test_reset();
      test_reset_mid_store();
      test_addu();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
